// File: rtl/priority_decoder_pkg.sv
// Shared types and widths for the timed one-hot priority decoder.
package priority_decoder_pkg;

  localparam int unsigned PD_CODE_W = 3;
  localparam int unsigned PD_OUT_W  = 8;
  localparam int unsigned PD_CNT_W  = 8;

  typedef enum logic [1:0] {
    PD_IDLE,
    PD_HOLD,
    PD_GAP
  } pd_state_t;

  function automatic logic [PD_OUT_W-1:0] pd_onehot(input logic [PD_CODE_W-1:0] code);
    return PD_OUT_W'(1) << code;
  endfunction

endpackage

// File: rtl/pd_dwell_counter.sv
// Loadable saturating down-counter timing both the hold and gap phases.
module pd_dwell_counter
  import priority_decoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PD_CNT_W-1:0] load_val,
  output logic                zero
);

  logic [PD_CNT_W-1:0] count;

  // Stops at zero rather than wrapping; a new load always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - PD_CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/priority_decoder.sv
// Timed one-hot decoder: drives y[{a,b,c}] for HOLD_CYCLES, then an idle gap.
// Optional one-entry pending register enabled by PRIORITY_DECODER_PENDING_EN.
module priority_decoder
  import priority_decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 d,
  output logic                 in_ready,
  output logic [PD_OUT_W-1:0]  y,
  output logic                 busy,
  output logic [PD_CODE_W-1:0] cur_code
);

  localparam logic [PD_CNT_W-1:0] HOLD_LOAD = PD_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PD_CNT_W-1:0] GAP_LOAD  =
    (GAP_CYCLES == 0) ? '0 : PD_CNT_W'(GAP_CYCLES - 1);

  pd_state_t            state;
  logic [PD_CODE_W-1:0] code_in;
  logic [PD_CODE_W-1:0] next_code;
  logic                 accept;
  logic                 zero;
  logic                 end_hold;
  logic                 hold_to_gap;
  logic                 dwell_done;
  logic                 start_in;
  logic                 start_pend;
  logic                 cnt_load;
  logic [PD_CNT_W-1:0]  cnt_load_val;
  logic                 pend_valid;
  logic [PD_CODE_W-1:0] pend_code;

  assign code_in = {a, b, c};
  assign accept  = d && in_ready;

  // Phase boundaries, all decided by the shared dwell counter reaching zero.
  assign end_hold    = (state == PD_HOLD) && zero;
  assign hold_to_gap = end_hold && (GAP_CYCLES != 0);
  assign dwell_done  = (end_hold && (GAP_CYCLES == 0)) || ((state == PD_GAP) && zero);

  // A queued code takes priority; otherwise a fresh accept starts directly.
  assign start_pend = dwell_done && pend_valid;
  assign start_in   = accept && ((state == PD_IDLE) || dwell_done);
  assign next_code  = start_pend ? pend_code : code_in;

  assign cnt_load     = start_pend || start_in || hold_to_gap;
  assign cnt_load_val = hold_to_gap ? GAP_LOAD : HOLD_LOAD;

`ifdef PRIORITY_DECODER_PENDING_EN
  logic fill_pend;

  assign fill_pend = accept && !start_in;
  assign in_ready  = !rst && ((state == PD_IDLE) || !pend_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_code  <= '0;
    end else if (start_pend) begin
      pend_valid <= 1'b0;
    end else if (fill_pend) begin
      pend_valid <= 1'b1;
      pend_code  <= code_in;
    end
  end
`else
  assign pend_valid = 1'b0;
  assign pend_code  = '0;
  assign in_ready   = !rst && (state == PD_IDLE);
`endif

  pd_dwell_counter u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (zero)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PD_IDLE;
      y        <= '0;
      busy     <= 1'b0;
      cur_code <= '0;
    end else if (start_pend || start_in) begin
      state    <= PD_HOLD;
      y        <= pd_onehot(next_code);
      busy     <= 1'b1;
      cur_code <= next_code;
    end else if (hold_to_gap) begin
      state <= PD_GAP;
      y     <= '0;
    end else if (dwell_done) begin
      state <= PD_IDLE;
      y     <= '0;
      busy  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_priority_decoder.sv
// Bench for priority_decoder: timeline reference model, directed and random stimulus.
module tb_priority_decoder;

  localparam int H0 = 4;
  localparam int G0 = 1;
  localparam int H1 = 1;
  localparam int G1 = 0;
`ifdef PRIORITY_DECODER_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a, b, c, d;
  logic [7:0] y;
  logic busy, in_ready;
  logic [2:0] cur_code;
  logic af, bf, cf, df;
  logic [7:0] y_f;
  logic busy_f, in_ready_f;
  logic [2:0] cur_code_f;

  priority_decoder #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .in_ready(in_ready), .y(y), .busy(busy), .cur_code(cur_code));

  priority_decoder #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1)) u_fast (
    .clk(clk), .rst(rst), .a(af), .b(bf), .c(cf), .d(df),
    .in_ready(in_ready_f), .y(y_f), .busy(busy_f), .cur_code(cur_code_f));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference: each dwell is a window [start, start+H) of y and [start, end) of busy.
  int       m_start[2];
  int       m_end[2];
  logic [2:0] m_code[2];
  logic [2:0] m_pend[2];
  bit       m_pv[2];
  bit       m_acc[2];

  function automatic int hp(int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int gp(int i);
    return (i == 0) ? G0 : G1;
  endfunction

  function automatic bit exp_ready(int i);
    if (rst) return 1'b0;
    if (PEND) return !m_pv[i];
    return cyc >= m_end[i];
  endfunction

  function automatic logic [12:0] exp_obs(int i);
    logic [7:0] ey;
    logic one;
    bit eb;
    one = 1'b1;
    ey = (cyc >= m_start[i] && cyc < m_start[i] + hp(i)) ? (8'(one) << m_code[i]) : 8'h00;
    eb = (cyc >= m_start[i]) && (cyc < m_end[i]);
    return {ey, eb, m_code[i], exp_ready(i)};
  endfunction

  function automatic logic [12:0] obs(int i);
    return (i == 0) ? {y, busy, cur_code, in_ready} : {y_f, busy_f, cur_code_f, in_ready_f};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_start[i] = -1000;
      m_end[i]   = -1;
      m_code[i]  = 3'd0;
      m_pend[i]  = 3'd0;
      m_pv[i]    = 1'b0;
      m_acc[i]   = 1'b0;
    end
  endtask

  task automatic model_start(int i, logic [2:0] code);
    m_start[i] = cyc;
    m_end[i]   = cyc + hp(i) + gp(i);
    m_code[i]  = code;
  endtask

  // Advance one clock: capture pre-edge inputs, update the model, settle #1 after the edge.
  task automatic step();
    bit r[2];
    bit dv[2];
    logic [2:0] in[2];
    for (int i = 0; i < 2; i++) r[i] = exp_ready(i);
    dv[0] = d;  in[0] = {a, b, c};
    dv[1] = df; in[1] = {af, bf, cf};
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 1'b0;
      if (!rst) begin
        if (m_pv[i] && cyc == m_end[i]) begin
          model_start(i, m_pend[i]);
          m_pv[i] = 1'b0;
        end else if (r[i] && dv[i]) begin
          m_acc[i] = 1'b1;
          if (cyc >= m_end[i]) model_start(i, in[i]);
          else begin
            m_pend[i] = in[i];
            m_pv[i]   = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  // Invariants on both instances, sampled away from the active edge.
  always @(negedge clk) begin
    n_vec++;
    if (!$onehot0(y) || !$onehot0(y_f) || (y != 8'h00 && !busy) || (y_f != 8'h00 && !busy_f)) begin
      n_err++;
      $display("FAIL invariant t=%0t y=%h busy=%b y_f=%h busy_f=%b", $time, y, busy, y_f, busy_f);
    end
  end

  task automatic test_reset();
    {a, b, c, d} = 4'b0;
    {af, bf, cf, df} = 4'b0;
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      step();
      n_vec++;
      if ({y, busy, cur_code, in_ready} !== 13'h0) begin
        n_err++;
        $display("FAIL reset_hold got=%h exp=%h", {y, busy, cur_code, in_ready}, 13'h0);
      end
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || obs(0) !== exp_obs(0)) begin
      n_err++;
      $display("FAIL reset_release got=%h exp=%h", obs(0), exp_obs(0));
    end
  endtask

  task automatic test_basic();
    logic [7:0] ey;
    {a, b, c} = 3'b101;
    d = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      d = 1'b0;
      ey = (k < 4) ? 8'h20 : 8'h00;
      n_vec++;
      if (y !== ey || obs(0) !== exp_obs(0)) begin
        n_err++;
        $display("FAIL basic k=%0d y=%h exp_y=%h got=%h exp=%h", k, y, ey, obs(0), exp_obs(0));
      end
    end
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_ready in_ready=%b busy=%b exp 1/0", in_ready, busy);
    end
  endtask

  task automatic test_code0();
    {a, b, c} = 3'b000;
    d = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      d = 1'b0;
      n_vec++;
      if ((k < 4 && (y !== 8'h01 || cur_code !== 3'd0)) || obs(0) !== exp_obs(0)) begin
        n_err++;
        $display("FAIL code0 k=%0d got=%h exp=%h", k, obs(0), exp_obs(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int first80;
    int exp80;
    first80 = -1;
    exp80 = PEND ? 5 : 6;
    {a, b, c} = 3'b001;
    d = 1'b1;
    step();
    {a, b, c} = 3'b111;
    for (int k = 1; k < 16; k++) begin
      step();
      if (m_acc[0]) d = 1'b0;
      if (y == 8'h80 && first80 < 0) first80 = k;
      n_vec++;
      if (obs(0) !== exp_obs(0)) begin
        n_err++;
        $display("FAIL b2b k=%0d got=%h exp=%h", k, obs(0), exp_obs(0));
      end
    end
    d = 1'b0;
    n_vec++;
    if (first80 != exp80) begin
      n_err++;
      $display("FAIL b2b_latency got=%0d exp=%0d", first80, exp80);
    end
  endtask

  task automatic test_reset_mid();
    {a, b, c} = 3'b011;
    d = 1'b1;
    step();
    d = 1'b0;
    step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({y, busy, in_ready} !== 10'h0 || obs(0) !== exp_obs(0)) begin
      n_err++;
      $display("FAIL reset_mid got=%h exp=%h", obs(0), exp_obs(0));
    end
    step();
    rst = 1'b0;
    {a, b, c} = 3'b110;
    d = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      d = 1'b0;
      n_vec++;
      if ((k < 4 && y !== 8'h40) || obs(0) !== exp_obs(0)) begin
        n_err++;
        $display("FAIL reset_mid_after k=%0d got=%h exp=%h", k, obs(0), exp_obs(0));
      end
    end
  endtask

  task automatic test_fast_stream();
    logic [2:0] seq[4];
    logic [7:0] ey[7];
    int idx;
    seq = '{3'd1, 3'd2, 3'd3, 3'd4};
    if (PEND) ey = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h00, 8'h00, 8'h00};
    else      ey = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h08, 8'h00, 8'h10};
    idx = 0;
    {af, bf, cf} = seq[0];
    df = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      if (m_acc[1]) begin
        idx++;
        if (idx < 4) {af, bf, cf} = seq[idx];
        else df = 1'b0;
      end
      n_vec++;
      if (y_f !== ey[k] || obs(1) !== exp_obs(1)) begin
        n_err++;
        $display("FAIL fast k=%0d y=%h exp_y=%h got=%h exp=%h", k, y_f, ey[k], obs(1), exp_obs(1));
      end
    end
    df = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (obs(0) !== exp_obs(0) || obs(1) !== exp_obs(1)) begin
          n_err++;
          $display("FAIL rand_reset k=%0d got=%h/%h exp=%h/%h", k, obs(0), obs(1), exp_obs(0), exp_obs(1));
        end
        step();
        rst = 1'b0;
      end
      d  = ($urandom_range(0, 99) < 60);
      df = ($urandom_range(0, 99) < 60);
      {a, b, c}    = 3'($urandom_range(0, 7));
      {af, bf, cf} = 3'($urandom_range(0, 7));
      step();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (obs(i) !== exp_obs(i)) begin
          n_err++;
          $display("FAIL rand inst=%0d k=%0d got=%h exp=%h", i, k, obs(i), exp_obs(i));
        end
      end
    end
    d = 1'b0;
    df = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_code0();
    test_back_to_back();
    test_reset_mid();
    test_fast_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
